// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit holding the HI/LO registers
//
// Accepts one multiply, divide, multiply-accumulate or mthi/mtlo operation at a
// time. The operation's full-width result is computed at the accept edge from the
// captured operands (and the {hi,lo} accumulator base). Busy is then held for a
// fixed number of cycles before {hi,lo} is committed. An in-flight operation can
// be aborted with cancel.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (wins over start and cancel)
//   start    issue op this cycle; accepted only when !busy and !cancel
//   op       0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//            7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 nop
//   src1     rs operand
//   src2     rt operand
//   cancel   abort the in-flight op / suppress a same-cycle start
//   busy     operation in flight (pipeline stall)
//   done     one-cycle pulse after the commit edge (or after a divide-by-zero finishes)
//   div0     one-cycle pulse alongside done when a div/divu had src2 == 0
//   hi, lo   architectural HI/LO registers

module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int DW         = 2 * WIDTH;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    pend_q, pend_d;
    logic             pdiv0_q, pdiv0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic             run;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             is_long;
    logic             last_cycle;

    assign run        = (state_q == S_RUN);
    assign accept     = start & ~run & ~cancel;
    assign is_mul     = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign is_div     = op inside {OP_DIV, OP_DIVU};
    assign is_long    = is_mul | is_div;
    assign last_cycle = (cnt_q == CNT_ONE);

    // ------------------------------------------------------------------
    // Result datapath, evaluated on the live inputs and used only at accept
    // ------------------------------------------------------------------
    logic             signed_op;
    logic [DW-1:0]    opa_ext;
    logic [DW-1:0]    opb_ext;
    logic [DW-1:0]    product;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    mul_res;

    // Extending both operands to 2*WIDTH makes the low 2*WIDTH bits of a plain
    // unsigned multiply equal the signed product modulo 2^(2*WIDTH).
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        opa_ext   = signed_op ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
        opb_ext   = signed_op ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
        product   = opa_ext * opb_ext;
        acc       = {hi_q, lo_q};
        if ((op == OP_MADD) || (op == OP_MADDU)) begin
            mul_res = acc + product;
        end else if ((op == OP_MSUB) || (op == OP_MSUBU)) begin
            mul_res = acc - product;
        end else begin
            mul_res = product;
        end
    end

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] uquot;
    logic [WIDTH-1:0] urem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // Signed division on magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. MIN/-1 naturally yields MIN with a
    // zero remainder because MIN's magnitude wraps back to MIN when negated.
    always_comb begin
        a_neg  = (op == OP_DIV) & src1[WIDTH-1];
        b_neg  = (op == OP_DIV) & src2[WIDTH-1];
        a_mag  = a_neg ? -src1 : src1;
        b_mag  = b_neg ? -src2 : src2;
        // A zero divisor is substituted so the divider never sees it; the result
        // is discarded on commit anyway.
        b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        uquot  = a_mag / b_safe;
        urem   = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -uquot : uquot;
        rem    = a_neg ? -urem : urem;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            pdiv0_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pdiv0_q <= pdiv0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (accept && is_long) begin
                state_d = S_RUN;
            end
        end else begin
            // cancel on the final cycle still wins over the commit
            if (cancel || last_cycle) begin
                state_d = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter, pending result and HI/LO update
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pdiv0_d = pdiv0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (run) begin
            if (cancel) begin
                cnt_d = '0;
            end else if (last_cycle) begin
                cnt_d = '0;
                if (!pdiv0_q) begin
                    {hi_d, lo_d} = pend_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (accept) begin
            if (is_long) begin
                cnt_d   = is_div ? DIV_N : MULT_N;
                pend_d  = is_div ? {rem, quot} : mul_res;
                pdiv0_d = is_div && (src2 == '0);
            end else if (op == OP_MTHI) begin
                hi_d = src1;
            end else if (op == OP_MTLO) begin
                lo_d = src1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        done_d = run & last_cycle & ~cancel;
        div0_d = run & last_cycle & ~cancel & pdiv0_q;
        busy   = run;
        done   = done_q;
        div0   = div0_q;
        hi     = hi_q;
        lo     = lo_q;
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq with directed and random ops
module tb_mdu_seq;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [3:0]   op     = 4'd0;
    logic [W-1:0] src1   = '0;
    logic [W-1:0] src2   = '0;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mdu_seq #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: architectural result of one op from the current HI/LO.
    // n is the busy length (0 for single-cycle or nop ops).
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] nh, output logic [W-1:0] nl,
                                  output bit dz, output int n);
        logic [63:0] sp;
        logic [63:0] up;
        logic [63:0] acc;
        int          sa;
        int          sb;
        nh  = m_hi;
        nl  = m_lo;
        dz  = 1'b0;
        n   = 0;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        case (o)
            4'd1:  begin {nh, nl} = sp;       n = MC; end
            4'd2:  begin {nh, nl} = up;       n = MC; end
            4'd7:  begin {nh, nl} = acc + sp; n = MC; end
            4'd8:  begin {nh, nl} = acc + up; n = MC; end
            4'd9:  begin {nh, nl} = acc - sp; n = MC; end
            4'd10: begin {nh, nl} = acc - up; n = MC; end
            4'd3: begin
                n = DC;
                if (b == 0) begin
                    dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = a;
                    nh = '0;
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    nl = sa / sb;
                    nh = sa % sb;
                end
            end
            4'd4: begin
                n = DC;
                if (b == 0) begin
                    dz = 1'b1;
                end else begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            4'd5: nh = a;
            4'd6: nl = a;
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chki("unexpected_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk32("done_hi", hi, mon_e.hi);
                    chk32("done_lo", lo, mon_e.lo);
                    chki("done_div0", int'(div0), int'(mon_e.dz));
                    chki("done_cycle", cyc, mon_e.cyc);
                end
            end else if (div0) begin
                chki("div0_without_done", 1, 0);
            end
        end
    end

    // Issues one op starting just after a rising edge with the DUT idle, then
    // follows it until busy falls. cancel_at = busy cycle (1-based) carrying
    // cancel; hold keeps start asserted with changing operands; cstart raises
    // cancel together with start.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int cancel_at, input bit hold, input bit cstart);
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        bit           dz;
        int           n;
        int           acc_c;
        int           bcnt;
        int           exp_b;
        int           to;
        model(o, a, b, nh, nl, dz, n);
        start  = 1'b1;
        op     = o;
        src1   = a;
        src2   = b;
        cancel = cstart;
        @(posedge clk);
        #1;
        acc_c  = cyc;
        cancel = 1'b0;
        if (!cstart) begin
            if (n > 0) begin
                if (cancel_at == 0) begin
                    sbq.push_back('{nh, nl, dz, acc_c + n});
                    m_hi = nh;
                    m_lo = nl;
                end
            end else begin
                m_hi = nh;
                m_lo = nl;
            end
        end
        if (!hold) start = 1'b0;
        exp_b = (cstart || n == 0) ? 0 : ((cancel_at > 0) ? cancel_at : n);
        bcnt  = 0;
        to    = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                to = 0;
                break;
            end
            bcnt++;
            if (i == cancel_at) cancel = 1'b1;
            @(posedge clk);
            #1;
            cancel = 1'b0;
            if (hold) begin
                src1 = $urandom;
                src2 = $urandom;
                op   = 4'($urandom_range(1, 4));
            end
        end
        start = 1'b0;
        chki("busy_timeout", to, 0);
        chki("busy_cycles", bcnt, exp_b);
        chk32("hi_after", hi, m_hi);
        chk32("lo_after", lo, m_lo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        bit           dz;
        int           n;
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           rc;
        bit           rh;
        bit           rs;

        // Reset state, with a start presented during reset that must be ignored
        start = 1'b1;
        op    = 4'd5;
        src1  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_div0", int'(div0), 0);
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: signed multiply
        issue(4'd1, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
        chk32("t1_hi", hi, 32'hFFFF_FFFF);
        chk32("t1_lo", lo, 32'hFFFF_FFEB);

        // 2: unsigned multiply then accumulate
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        chk32("t2_hi", hi, 32'h0000_0001);
        chk32("t2_lo", lo, 32'hFFFF_FFFE);
        issue(4'd7, 32'd1, 32'd1, 0, 0, 0);
        chk32("t2_madd_lo", lo, 32'hFFFF_FFFF);

        // 3: signed divide, including MIN / -1
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        chk32("t3_lo", lo, 32'hFFFF_FFFD);
        chk32("t3_hi", hi, 32'hFFFF_FFFF);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        chk32("t3_min_lo", lo, 32'h8000_0000);
        chk32("t3_min_hi", hi, 32'h0);

        // 4: divide by zero leaves HI/LO alone
        issue(4'd5, 32'h12, 32'd0, 0, 0, 0);
        issue(4'd6, 32'h34, 32'd0, 0, 0, 0);
        issue(4'd4, 32'd55, 32'd0, 0, 0, 0);
        chk32("t4_hi", hi, 32'h12);
        chk32("t4_lo", lo, 32'h34);

        // 5: cancel mid-flight, on the final cycle, and with a same-cycle mthi
        issue(4'd1, 32'd5, 32'd6, 3, 0, 0);
        issue(4'd3, 32'd100, 32'd7, DC, 0, 0);
        issue(4'd5, 32'hDEAD_BEEF, 32'd0, 0, 0, 1);
        chk32("t5_hi", hi, 32'h12);

        // 6: start held while busy with changing operands
        issue(4'd2, 32'd1234, 32'd5678, 0, 1, 0);
        chk32("t6_lo", lo, 32'd7006652);

        // 6: reset in the middle of a divide
        start = 1'b1;
        op    = 4'd4;
        src1  = 32'd1000;
        src2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        @(negedge clk);
        chki("t6_rst_busy", int'(busy), 0);
        chk32("t6_rst_hi", hi, 32'h0);
        chk32("t6_rst_lo", lo, 32'h0);
        @(posedge clk);
        #1;

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: ra = 32'h8000_0000;
                3: rb = 32'(($urandom_range(0, 15)));
                default: ;
            endcase
            model(ro, ra, rb, nh, nl, dz, n);
            rc = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, n)) : 0;
            rh = (n > 0 && rc == 0 && $urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 7) == 0);
            if (rs) begin
                rc = 0;
                rh = 1'b0;
            end
            issue(ro, ra, rb, rc, rh, rs);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        chki("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
